// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the register-file writeback port arbiter.
// Address and data widths are fixed here so every user of the port agrees on them.
package wb_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    PRIO0  = 1'b0,
    FORCE1 = 1'b1
  } arb_state_t;

  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_LD  = 1'b1;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: two requesters with valid/ready handshakes, a stall input,
// and the registered register-file write produced by the arbiter.
interface wb_port_arbiter_if;
  import wb_arb_pkg::*;

  logic              stall;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              wb_sel;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              starved;

  modport master (
    output stall, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, wb_sel, wb_we, wb_addr, wb_data, starved
  );

  modport slave (
    input  stall, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, wb_sel, wb_we, wb_addr, wb_data, starved
  );

endinterface

// File: rtl/MUX_5_2_1.sv
// 5-bit 2:1 multiplexer used to select the winning destination register address.
module MUX_5_2_1 (
  input  logic [4:0] in_0,
  input  logic [4:0] in_1,
  input  logic       sel,
  output logic [4:0] out
);

  assign out = sel ? in_1 : in_0;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between ALU (req0) and load (req1) writebacks:
// fixed priority to req0, with a starvation guard that forces a req1 grant.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               rst_n,
  wb_port_arbiter_if.slave  bus
);

  localparam logic [3:0] W_MAX = 4'(STARVE_MAX);

  arb_state_t        r_state;
  logic [3:0]        r_starve_cnt;
  logic              r_we;
  logic              r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_fire;
  logic              w_sel;
  logic              w_wait1;
  logic              w_starve_hit;
  logic [3:0]        w_cnt_next;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  // In FORCE1 req0 is locked out, so req1 wins whenever it is valid.
  assign w_grant0 = rst_n && !bus.stall && bus.req0_valid && (r_state == PRIO0);
  assign w_grant1 = rst_n && !bus.stall && bus.req1_valid && !w_grant0;
  assign w_fire   = w_grant0 || w_grant1;
  assign w_sel    = w_grant1 ? GRANT_LD : GRANT_ALU;
  assign w_wait1  = rst_n && !bus.stall && bus.req1_valid && !w_grant1;

  MUX_5_2_1 u_addr_mux (
    .in_0 (bus.req0_addr),
    .in_1 (bus.req1_addr),
    .sel  (w_sel),
    .out  (w_addr)
  );

  assign w_data = w_grant1 ? bus.req1_data : bus.req0_data;

  always_comb begin
    w_cnt_next = r_starve_cnt;
    if (w_grant1) begin
      w_cnt_next = 4'd0;
    end else if (w_wait1 && (r_starve_cnt != W_MAX)) begin
      w_cnt_next = r_starve_cnt + 4'd1;
    end
  end

  // Only a cycle in which req1 actually lost may trigger the force, so a saturated
  // counter left over from a dropped request cannot lock out req0 on its own.
  assign w_starve_hit = w_wait1 && (w_cnt_next == W_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= PRIO0;
      r_starve_cnt <= 4'd0;
      r_we         <= 1'b0;
      r_sel        <= GRANT_ALU;
      r_addr       <= REG_ZERO;
      r_data       <= '0;
    end else begin
      r_starve_cnt <= w_cnt_next;
      case (r_state)
        PRIO0:   if (w_starve_hit) r_state <= FORCE1;
        FORCE1:  if (!bus.stall && (w_grant1 || !bus.req1_valid)) r_state <= PRIO0;
        default: r_state <= PRIO0;
      endcase
      r_we <= w_fire && (w_addr != REG_ZERO);
      if (w_fire) begin
        r_sel  <= w_sel;
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  // Gating with rst_n keeps a write already in the output register off the port while reset is held.
  assign bus.wb_we      = r_we && rst_n;
  assign bus.wb_sel     = r_sel;
  assign bus.wb_addr    = r_addr;
  assign bus.wb_data    = r_data;
  assign bus.starved    = (r_state == FORCE1);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected writes are queued when a grant is
// expected and compared against the registered write port one cycle later.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  typedef struct packed {
    logic        we;
    logic        sel;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.STARVE_MAX(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  wr_t q[$];
  logic        m_sel;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: check handshake outputs, queue the expected write,
  // then after the edge compare the write port against the queue head.
  task automatic step(input string tag, input logic e0, input logic e1, input logic es);
    wr_t w;
    #2;
    check({tag, ".rdy0"}, 64'(bus.req0_ready), 64'(e0));
    check({tag, ".rdy1"}, 64'(bus.req1_ready), 64'(e1));
    check({tag, ".starved"}, 64'(bus.starved), 64'(es));
    if (e0) begin
      w.we = (bus.req0_addr != 5'd0); w.sel = 1'b0;
      w.addr = bus.req0_addr; w.data = bus.req0_data;
      q.push_back(w);
    end
    if (e1) begin
      w.we = (bus.req1_addr != 5'd0); w.sel = 1'b1;
      w.addr = bus.req1_addr; w.data = bus.req1_data;
      q.push_back(w);
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      w = q.pop_front();
      m_sel = w.sel; m_addr = w.addr; m_data = w.data;
      check({tag, ".we"}, 64'(bus.wb_we), 64'(w.we));
    end else begin
      check({tag, ".we_idle"}, 64'(bus.wb_we), 64'(1'b0));
    end
    check({tag, ".sel"}, 64'(bus.wb_sel), 64'(m_sel));
    check({tag, ".addr"}, 64'(bus.wb_addr), 64'(m_addr));
    check({tag, ".data"}, 64'(bus.wb_data), 64'(m_data));
    $display("%-10s t=%0t rdy0=%0b rdy1=%0b starved=%0b we=%0b sel=%0b addr=%0d data=%08h",
             tag, $time, e0, e1, es, bus.wb_we, bus.wb_sel, bus.wb_addr, bus.wb_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    bus.stall = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h1111_1111;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h2222_2222;
    m_sel = 1'b0; m_addr = 5'd0; m_data = 32'd0;

    // Reset state, with both requesters asserting valid
    repeat (2) @(posedge clk);
    #1;
    check("rst.rdy0", 64'(bus.req0_ready), 64'(1'b0));
    check("rst.rdy1", 64'(bus.req1_ready), 64'(1'b0));
    check("rst.we", 64'(bus.wb_we), 64'(1'b0));
    check("rst.sel", 64'(bus.wb_sel), 64'(1'b0));
    check("rst.addr", 64'(bus.wb_addr), 64'(5'd0));
    check("rst.data", 64'(bus.wb_data), 64'(32'd0));
    check("rst.starved", 64'(bus.starved), 64'(1'b0));
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst_n = 1'b1;

    // 1: single ALU write
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA5A5_0001;
    step("t1", 1'b1, 1'b0, 1'b0);
    bus.req0_valid = 1'b0;
    step("t1.idle", 1'b0, 1'b0, 1'b0);

    // 3: load write to r0 is accepted but not written
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'hFFFF_FFFF;
    step("t3", 1'b0, 1'b1, 1'b0);
    bus.req1_valid = 1'b0;
    step("t3.idle", 1'b0, 1'b0, 1'b0);

    // 6: back-to-back ALU writes, no bubbles
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd7;
    for (int d = 1; d <= 3; d++) begin
      bus.req0_data = 32'(d);
      step("t6", 1'b1, 1'b0, 1'b0);
    end
    bus.req0_valid = 1'b0;
    step("t6.idle", 1'b0, 1'b0, 1'b0);

    // 2: contention, req1 forced through after three losses
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd4;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd5; bus.req1_data = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      bus.req0_data = 32'h100 + 32'(i);
      step("t2.prio", 1'b1, 1'b0, 1'b0);
    end
    step("t2.force", 1'b0, 1'b1, 1'b1);
    bus.req1_data = 32'h0000_0201;
    bus.req0_data = 32'h110;
    step("t2.back", 1'b1, 1'b0, 1'b0);
    bus.req0_data = 32'h111;
    step("t2.back", 1'b1, 1'b0, 1'b0);

    // 4: stall holds the starvation count (two losses already recorded)
    bus.stall = 1'b1;
    step("t4.stall", 1'b0, 1'b0, 1'b0);
    step("t4.stall", 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b0;
    bus.req0_data = 32'h112;
    step("t4.resume", 1'b1, 1'b0, 1'b0);
    step("t4.force", 1'b0, 1'b1, 1'b1);

    // 5: reset right after a load fire
    bus.req0_valid = 1'b0;
    bus.req1_addr = 5'd9; bus.req1_data = 32'h0000_BEEF;
    step("t5.fire", 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5.gate_we", 64'(bus.wb_we), 64'(1'b0));
    check("t5.gate_rdy1", 64'(bus.req1_ready), 64'(1'b0));
    @(posedge clk);
    #1;
    check("t5.we", 64'(bus.wb_we), 64'(1'b0));
    check("t5.starved", 64'(bus.starved), 64'(1'b0));
    check("t5.sel", 64'(bus.wb_sel), 64'(1'b0));
    check("t5.addr", 64'(bus.wb_addr), 64'(5'd0));
    check("t5.data", 64'(bus.wb_data), 64'(32'd0));
    $display("t5.reset   t=%0t we=%0b starved=%0b", $time, bus.wb_we, bus.starved);
    rst_n = 1'b1;
    m_sel = 1'b0; m_addr = 5'd0; m_data = 32'd0;

    // Counter cleared by reset; FORCE1 exits when req1 withdraws
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd12; bus.req0_data = 32'hC0DE_0000;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd13; bus.req1_data = 32'hC0DE_1111;
    for (int i = 0; i < 3; i++) begin
      step("drop.prio", 1'b1, 1'b0, 1'b0);
    end
    bus.req1_valid = 1'b0;
    step("drop.force", 1'b0, 1'b0, 1'b1);
    step("drop.back", 1'b1, 1'b0, 1'b0);
    bus.req0_valid = 1'b0;
    step("end.idle", 1'b0, 1'b0, 1'b0);

    check("end.queue_empty", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
